kb_code_display: RTL and testbench
==================================

# kb_code_display

Consumes completed scan codes from the PS/2 keyboard decoder and keeps a short history of the most recent key presses. It drives a time-multiplexed, active-low 7-segment display with those codes in hex and counts make events. It sits directly downstream of the keyboard decoder and directly upstream of the board's display pins.

## Interface
Parameters:
- DIGITS, 8, number of display digits; even, 2..8; history depth is DIGITS/2 entries
- REFRESH_DIV, 16, CLK cycles per digit slot; ≥2

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, same clock as the decoder
- ARST  in  1  asynchronous reset, active-high
- CODE_VALID  in  1  one-cycle strobe: a complete scan code is present
- HEX1  in  4  upper nibble of scan code, sampled on CODE_VALID
- HEX0  in  4  lower nibble of scan code, sampled on CODE_VALID
- KEYUP  in  1  sampled with CODE_VALID; 1 = break (release), 0 = make
- CLEAR  in  1  synchronous clear of history and counter
- AN  out  DIGITS  digit enables, active-low, one-hot-zero
- SEG  out  7  {g,f,e,d,c,b,a}, active-low
- DP  out  1  decimal point, active-low
- COUNT  out  8  accepted make events, mod 256

## Operation
- History: DIGITS/2 entries; each entry is {valid, held, code[7:0]}. Entry 0 is the newest.
- Make (CODE_VALID=1, KEYUP=0), code C = {HEX1,HEX0}:
  - If entry0 is valid, holds C, and is held, the event is a typematic repeat: no change, COUNT unchanged.
  - Otherwise shift entries up by one (the oldest entry drops out). Entry0 becomes {1,1,C}. COUNT increments and wraps 255→0.
- Break (KEYUP=1): every valid entry with code C has held cleared. There is no shift and no COUNT change. A break for a code that is not present is ignored.
- CLEAR: all entries become invalid and COUNT=0. CLEAR takes priority over a simultaneous CODE_VALID; that event is lost.
- Display: digit d shows entry d/2. Even d shows the low nibble and odd d shows the high nibble.
  - An invalid entry shows blank: SEG=7'h7F, DP=1.
  - DP=0 only on the even digit of a held entry.
- Refresh: the divider counts 0..REFRESH_DIV-1. On wrap, the digit index advances d→d+1, and DIGITS-1→0.

## Timing
- Reset values: AN all ones, SEG=7'h7F, DP=1, COUNT=0, all entries invalid, divider=0, digit index=0.
- The history and COUNT update on the CLK edge that samples CODE_VALID, so the new values are visible the next cycle.
- AN/SEG/DP are registered. They reflect the digit index and history of the previous cycle, so the display latency from a history update is at most 1 cycle plus the wait for the digit's slot.
- Each digit is active for exactly REFRESH_DIV cycles per frame. The frame length is DIGITS·REFRESH_DIV cycles.
- The first frame after reset starts with AN[0] low in cycle 1.
- ARST asserted mid-frame or mid-event returns every output to its reset value immediately, independent of CLK.
- CODE_VALID on consecutive cycles: each event is processed in order, one per cycle.

## Structure
- Shared package kb_pkg holds:
  - SEG_BLANK = 7'h7F
  - the segment-order constants
  - the history-entry typedef {valid, held, code}
- Sub-module hex_to_seg7 is combinational. It maps 4-bit hex to the active-low SEG pattern (0→7'h40, 1→7'h79, C→7'h46, F→7'h0E).
- The history register, event logic, refresh divider and output registers stay in kb_code_display.

## Test plan
- Reset: ARST high → AN=8'hFF, SEG=7'h7F, DP=1, COUNT=0. Release ARST, run one frame → every digit blank.
- Single make: strobe HEX1=1, HEX0=C, KEYUP=0 → COUNT=1.
  - Digit 0 slot: SEG=7'h46, DP=0.
  - Digit 1 slot: SEG=7'h79, DP=1.
  - Digits 2–7 blank.
- Repeat then release: strobe 1C make ×3 → COUNT stays 1. Then strobe 1C with KEYUP=1 → digit 0 DP=1 and the code is still displayed.
- History overflow: makes 16, 1E, 26, 25, 2E with breaks between (DIGITS=8) → entries show 2E, 25, 26, 1E, and 16 is gone. COUNT=5.
- Clear collision: CLEAR and CODE_VALID in the same cycle → history empty, COUNT=0. The next make gives COUNT=1.
- Counter wrap and refresh: 256 distinct-alternating makes → COUNT=0. AN low pulses are exactly REFRESH_DIV cycles each, in order 0..7. Assert ARST mid-slot → outputs return to reset values immediately.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard code display: segment bit masks,
// blank pattern and the history-entry record.
package kb_pkg;

    // Segment bit masks in the {g,f,e,d,c,b,a} bus order, active-high "lit" sense.
    localparam logic [6:0] SEG_A = 7'b000_0001;
    localparam logic [6:0] SEG_B = 7'b000_0010;
    localparam logic [6:0] SEG_C = 7'b000_0100;
    localparam logic [6:0] SEG_D = 7'b000_1000;
    localparam logic [6:0] SEG_E = 7'b001_0000;
    localparam logic [6:0] SEG_F = 7'b010_0000;
    localparam logic [6:0] SEG_G = 7'b100_0000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       valid;
        logic       held;
        logic [7:0] code;
    } hist_entry_t;

    localparam hist_entry_t HIST_EMPTY = '{valid: 1'b0, held: 1'b0, code: 8'h00};

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-digit font: 4-bit value to active-low {g,f,e,d,c,b,a}.
module hex_to_seg7
    import kb_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] lit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        lit = '0;
        case (hex)
            4'h0: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'h1: lit = SEG_B | SEG_C;
            4'h2: lit = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'h3: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'h4: lit = SEG_B | SEG_C | SEG_F | SEG_G;
            4'h5: lit = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'h6: lit = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h7: lit = SEG_A | SEG_B | SEG_C;
            4'h8: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h9: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            4'hA: lit = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
            4'hB: lit = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'hC: lit = SEG_A | SEG_D | SEG_E | SEG_F;
            4'hD: lit = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
            4'hE: lit = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
            4'hF: lit = SEG_A | SEG_E | SEG_F | SEG_G;
            default: lit = '0;
        endcase
        seg = ~lit;
    end

endmodule

// File: rtl/kb_code_display.sv
// Keeps a short history of recent key presses from the PS/2 decoder, counts
// make events and scans the history onto a multiplexed 7-segment display.
module kb_code_display
    import kb_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 16
)
(
    input  logic              CLK,
    input  logic              ARST,
    input  logic              CODE_VALID,
    input  logic [3:0]        HEX1,
    input  logic [3:0]        HEX0,
    input  logic              KEYUP,
    input  logic              CLEAR,
    output logic [DIGITS-1:0] AN,
    output logic [6:0]        SEG,
    output logic              DP,
    output logic [7:0]        COUNT
);

    localparam int DEPTH = DIGITS / 2;
    localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW    = $clog2(REFRESH_DIV);

    hist_entry_t    hist [DEPTH];
    logic [7:0]     code_in;
    logic           is_repeat;
    logic [RW-1:0]  div_cnt;
    logic [DW-1:0]  digit;
    hist_entry_t    sel;
    logic [3:0]     nib;
    logic [6:0]     font_seg;

    assign code_in   = {HEX1, HEX0};
    // A make for the key already newest and still held is auto-repeat, not a new press.
    assign is_repeat = hist[0].valid && hist[0].held && (hist[0].code == code_in);

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            // NOTE: the history is a handful of flops that must read as empty after reset, so it is reset like any control state.
            for (int i = 0; i < DEPTH; i++) hist[i] <= HIST_EMPTY;
            COUNT <= 8'h00;
        end else if (CLEAR) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= HIST_EMPTY;
            COUNT <= 8'h00;
        end else if (CODE_VALID) begin
            if (!KEYUP) begin
                if (!is_repeat) begin
                    for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
                    hist[0] <= '{valid: 1'b1, held: 1'b1, code: code_in};
                    COUNT   <= COUNT + 8'd1;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (hist[i].valid && (hist[i].code == code_in)) hist[i].held <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            div_cnt <= '0;
            digit   <= '0;
        end else if (div_cnt == RW'(REFRESH_DIV - 1)) begin
            div_cnt <= '0;
            digit   <= (digit == DW'(DIGITS - 1)) ? '0 : digit + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Digit d shows entry d/2: low nibble on even digits, high nibble on odd.
    always_comb begin
        sel = HIST_EMPTY;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(digit) / 2 == i) sel = hist[i];
        end
        nib = digit[0] ? sel.code[7:4] : sel.code[3:0];
    end

    hex_to_seg7 u_font (
        .hex (nib),
        .seg (font_seg)
    );

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            AN  <= '1;
            SEG <= SEG_BLANK;
            DP  <= 1'b1;
        end else begin
            AN  <= ~(DIGITS'(1) << digit);
            SEG <= sel.valid ? font_seg : SEG_BLANK;
            DP  <= ~(sel.valid && sel.held && !digit[0]);
        end
    end

endmodule

// File: tb/tb_kb_code_display.sv
// Randomised and directed bench for kb_code_display: a queue-based history model
// predicts each display slot, and a monitor compares slots as the DUT scans them.
module tb_kb_code_display;

    localparam int DIGITS = 8;
    localparam int R      = 16;
    localparam int FRAME  = DIGITS * R;
    localparam int DEPTH  = DIGITS / 2;

    logic              CLK = 1'b0;
    logic              ARST = 1'b1;
    logic              CODE_VALID = 1'b0;
    logic [3:0]        HEX1 = 4'h0;
    logic [3:0]        HEX0 = 4'h0;
    logic              KEYUP = 1'b0;
    logic              CLEAR = 1'b0;
    logic [DIGITS-1:0] AN;
    logic [6:0]        SEG;
    logic              DP;
    logic [7:0]        COUNT;

    kb_code_display #(.DIGITS(DIGITS), .REFRESH_DIV(R)) dut (
        .CLK        (CLK),
        .ARST       (ARST),
        .CODE_VALID (CODE_VALID),
        .HEX1       (HEX1),
        .HEX0       (HEX0),
        .KEYUP      (KEYUP),
        .CLEAR      (CLEAR),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP),
        .COUNT      (COUNT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: newest-first list of pressed keys plus a make counter.
    typedef struct { logic [7:0] code; bit held; } ent_t;
    ent_t mq[$];
    int   m_count = 0;

    function automatic void model_event(bit v, logic [7:0] c, bit ku, bit clr);
        if (clr) begin
            mq.delete();
            m_count = 0;
        end else if (v && !ku) begin
            if (mq.size() > 0 && mq[0].code == c && mq[0].held) return;
            mq.push_front('{code: c, held: 1'b1});
            if (mq.size() > DEPTH) mq.delete(mq.size() - 1);
            m_count = (m_count + 1) % 256;
        end else if (v) begin
            foreach (mq[i]) if (mq[i].code == c) mq[i].held = 1'b0;
        end
    endfunction

    // Font as lists of lit segment letters.
    string lit_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] seg_of(logic [3:0] n);
        string s;
        logic [6:0] p;
        s = lit_tbl[n];
        p = 7'h7F;
        for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 97] = 1'b0;
        return p;
    endfunction

    typedef struct { logic [DIGITS-1:0] an; logic [6:0] seg; logic dp; logic [7:0] count; } slot_t;
    slot_t exp_q[$];

    // Edges since reset release; the slot for edge t shows digit ((t-1)/R) mod DIGITS.
    int cyc = 0;
    always @(posedge CLK or posedge ARST) begin
        if (ARST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Monitor: at each new slot, compare against the next expected slot and check slot length.
    logic [DIGITS-1:0] prev_an = '1;
    int                run_len = 0;
    always @(negedge CLK) begin
        if (ARST) begin
            prev_an <= '1;
            run_len <= 0;
        end else if (AN !== prev_an) begin
            if (prev_an !== '1) check("slot_len", run_len, R);
            if (exp_q.size() > 0) begin
                check("an",    AN,    exp_q[0].an);
                check("seg",   SEG,   exp_q[0].seg);
                check("dp",    DP,    exp_q[0].dp);
                check("count", COUNT, exp_q[0].count);
                exp_q.delete(0);
            end
            prev_an <= AN;
            run_len <= 1;
        end else begin
            run_len <= run_len + 1;
        end
    end

    task automatic ev(bit v, logic [7:0] c, bit ku, bit clr);
        @(negedge CLK);
        CODE_VALID = v;
        HEX1       = c[7:4];
        HEX0       = c[3:0];
        KEYUP      = ku;
        CLEAR      = clr;
        model_event(v, c, ku, clr);
    endtask

    task automatic idle();
        @(negedge CLK);
        CODE_VALID = 1'b0;
        KEYUP      = 1'b0;
        CLEAR      = 1'b0;
    endtask

    task automatic check_frame();
        slot_t s;
        int    e;
        int    waited;
        logic [3:0] n;
        idle();
        repeat (2) @(negedge CLK);
        while (cyc % FRAME != 0) @(negedge CLK);
        for (int d = 0; d < DIGITS; d++) begin
            e     = d / 2;
            s.an  = ~(DIGITS'(1) << d);
            if (e < mq.size()) begin
                n     = (d % 2 == 1) ? mq[e].code[7:4] : mq[e].code[3:0];
                s.seg = seg_of(n);
                s.dp  = !(mq[e].held && (d % 2 == 0));
            end else begin
                s.seg = 7'h7F;
                s.dp  = 1'b1;
            end
            s.count = m_count[7:0];
            exp_q.push_back(s);
        end
        waited = 0;
        while (exp_q.size() > 0 && waited < FRAME + 8) begin
            @(negedge CLK);
            waited++;
        end
        if (exp_q.size() > 0) begin
            check("frame_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_an"},    AN,    {DIGITS{1'b1}});
        check({tag, "_seg"},   SEG,   7'h7F);
        check({tag, "_dp"},    DP,    1'b1);
        check({tag, "_count"}, COUNT, 8'h00);
    endtask

    logic [7:0] codes [4] = '{8'h1C, 8'h2A, 8'h5B, 8'hE7};
    logic [7:0] ovf   [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

    initial begin
        logic [7:0] ca, cb, c;
        int r;

        repeat (2) @(negedge CLK);
        check_reset_outputs("reset");
        @(negedge CLK);
        ARST = 1'b0;
        check_frame();

        // Single make of 1C
        ev(1, 8'h1C, 0, 0);
        check_frame();

        // Typematic repeats, then release
        for (int i = 0; i < 3; i++) ev(1, 8'h1C, 0, 0);
        check_frame();
        ev(1, 8'h1C, 1, 0);
        check_frame();

        // History overflow with breaks between all but the last make
        ev(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) begin
            ev(1, ovf[i], 0, 0);
            if (i < 4) ev(1, ovf[i], 1, 0);
        end
        check_frame();

        // CLEAR collides with a make: the make is lost
        ev(1, 8'h33, 0, 1);
        check_frame();
        ev(1, 8'h4D, 0, 0);
        check_frame();

        // Random back-to-back events
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            c = codes[$urandom_range(0, 3)];
            if (r < 5)       ev(1, c, 0, 0);
            else if (r < 8)  ev(1, c, 1, 0);
            else if (r == 8) ev(0, c, 0, 0);
            else             ev(1, c, 0, ($urandom_range(0, 3) == 0));
            if (i % 15 == 14) check_frame();
        end

        // Counter wrap: 256 makes alternating between two distinct codes
        ev(0, 8'h00, 0, 1);
        ca = 8'($urandom_range(0, 255));
        cb = ca ^ 8'h5A;
        for (int i = 0; i < 256; i++) ev(1, (i % 2 == 0) ? ca : cb, 0, 0);
        check_frame();

        // Asynchronous reset in the middle of a slot
        ev(1, 8'hA7, 0, 0);
        check_frame();
        repeat (R / 2 + 3) @(negedge CLK);
        #2 ARST = 1'b1;
        #1 check_reset_outputs("arst_mid");
        mq.delete();
        m_count = 0;
        repeat (2) @(negedge CLK);
        ARST = 1'b0;
        check_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
